// File: rtl/misr_pkg.sv
// rtl/misr_pkg.sv - shared types and helpers for the MISR response analyzer
//
// Contents:
//   state_t : session state (IDLE, COMPACT, DONE)
//   clog2   : ceiling log2, used to size the pattern counter

package misr_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPACT = 2'd1,
        DONE    = 2'd2
    } state_t;

    // Number of bits needed to hold values 0..value-1 (minimum 1 for value <= 2).
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        if (r == 0) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/misr_core.sv
// rtl/misr_core.sv - multiple-input signature register with seed load and enable
//
// Ports:
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset, forces signature to SEED
//   load      : reload SEED on the next edge (wins over enable)
//   enable    : fold data_in into the signature on the next edge
//   data_in   : response word to compact
//   signature : current register contents

module misr_core #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'(8'h1D),
    parameter logic [WIDTH-1:0] SEED  = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             enable,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] signature
);

    // Stage 0 always takes the MSB feedback, so POLY[0] is replaced by a 1.
    localparam logic [WIDTH-1:0] TAPS = {POLY[WIDTH-1:1], 1'b1};

    logic [WIDTH-1:0] sig_q;
    logic [WIDTH-1:0] sig_next;

    always_comb begin
        sig_next = {sig_q[WIDTH-2:0], 1'b0} ^ data_in ^ (TAPS & {WIDTH{sig_q[WIDTH-1]}});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= SEED;
        end else if (load) begin
            sig_q <= SEED;
        end else if (enable) begin
            sig_q <= sig_next;
        end
    end

    assign signature = sig_q;

endmodule

// File: rtl/misr_response_analyzer.sv
// rtl/misr_response_analyzer.sv - session controller compacting PATTERN_COUNT responses into a MISR
//
// Ports:
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset
//   start      : one-cycle pulse beginning a session (ignored while busy)
//   abort      : synchronous return to IDLE with reseed; highest priority
//   data_valid : data_in holds a response word this cycle
//   data_in    : response word
//   busy       : session in progress
//   done       : session complete, signature frozen
//   pass       : signature matches GOLDEN, only while done
//   signature  : current MISR contents

module misr_response_analyzer
    import misr_pkg::*;
#(
    parameter int               WIDTH         = 8,
    parameter logic [WIDTH-1:0] POLY          = WIDTH'(8'h1D),
    parameter logic [WIDTH-1:0] SEED          = '0,
    parameter int               PATTERN_COUNT = 256,
    parameter logic [WIDTH-1:0] GOLDEN        = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             data_valid,
    input  logic [WIDTH-1:0] data_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH-1:0] signature
);

    localparam int               CNT_W = clog2(PATTERN_COUNT + 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(PATTERN_COUNT - 1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] count;
    logic             reseed;
    logic             accept;

    // start only reseeds outside COMPACT; abort overrides both start and data.
    assign reseed = !abort && start && (state != COMPACT);
    assign accept = !abort && data_valid && (state == COMPACT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (abort) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state_next = COMPACT;
                COMPACT: if (data_valid && count == LAST) state_next = DONE;
                DONE:    if (start) state_next = COMPACT;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        busy = (state == COMPACT);
        done = (state == DONE);
        pass = (state == DONE) && (signature == GOLDEN);
    end

    // Counter stops at PATTERN_COUNT because the FSM leaves COMPACT on that word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (abort || reseed) begin
            count <= '0;
        end else if (accept) begin
            count <= count + CNT_W'(1);
        end
    end

    misr_core #(
        .WIDTH (WIDTH),
        .POLY  (POLY),
        .SEED  (SEED)
    ) u_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (abort || reseed),
        .enable    (accept),
        .data_in   (data_in),
        .signature (signature)
    );

endmodule

// File: tb/tb_misr_response_analyzer.sv
// tb/tb_misr_response_analyzer.sv - self-checking bench for misr_response_analyzer

module tb_misr_response_analyzer;

    localparam int         W   = 4;
    localparam logic [3:0] P   = 4'b0011;
    localparam logic [3:0] SD  = 4'b0000;
    localparam int         PC  = 2;
    localparam logic [3:0] GLD = 4'b0010;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       data_valid = 1'b0;
    logic [3:0] data_in = 4'h0;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] signature;

    int n_vec = 0;
    int n_bad = 0;

    // Reference session model: phase name, signature, words accepted.
    string m_phase;
    int    m_sig;
    int    m_cnt;

    misr_response_analyzer #(
        .WIDTH         (W),
        .POLY          (P),
        .SEED          (SD),
        .PATTERN_COUNT (PC),
        .GOLDEN        (GLD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .data_valid (data_valid),
        .data_in    (data_in),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .signature  (signature)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Signature step as polynomial arithmetic: shift, add data, reduce by taps when MSB falls out.
    function automatic int misr_step(input int s, input int d);
        int r;
        r = ((s << 1) & 15) ^ (d & 15);
        if (((s >> 3) & 1) == 1) begin
            r = r ^ (int'(P) | 1);
        end
        return r & 15;
    endfunction

    task automatic model_reset();
        m_phase = "idle";
        m_sig   = int'(SD);
        m_cnt   = 0;
    endtask

    task automatic model_clock();
        if (abort) begin
            model_reset();
        end else if (m_phase == "compact") begin
            if (data_valid) begin
                m_sig = misr_step(m_sig, int'(data_in));
                m_cnt = m_cnt + 1;
                if (m_cnt == PC) m_phase = "done";
            end
        end else if (start) begin
            m_phase = "compact";
            m_sig   = int'(SD);
            m_cnt   = 0;
        end
    endtask

    task automatic check_model(input string tag);
        logic exp_done;
        exp_done = (m_phase == "done");
        check({tag, ".busy"}, 32'(busy), 32'(m_phase == "compact"));
        check({tag, ".done"}, 32'(done), 32'(exp_done));
        check({tag, ".pass"}, 32'(pass), 32'(exp_done && (m_sig == int'(GLD))));
        check({tag, ".sig"},  32'(signature), 32'(m_sig));
    endtask

    task automatic cycle(input string tag, input logic s, input logic a, input logic v, input logic [3:0] d);
        start      = s;
        abort      = a;
        data_valid = v;
        data_in    = d;
        @(posedge clk);
        model_clock();
        #1;
        check_model(tag);
    endtask

    initial begin
        model_reset();
        #3;
        check("reset.sig",  32'(signature), 32'h0);
        check("reset.busy", 32'(busy), 32'h0);
        check("reset.done", 32'(done), 32'h0);
        check("reset.pass", 32'(pass), 32'h0);
        rst_n = 1'b1;

        // Basic two-word session that matches GOLDEN.
        cycle("s1.start", 1, 0, 0, 4'h0);
        check("s1.busy1", 32'(busy), 32'h1);
        cycle("s1.w0", 0, 0, 1, 4'b0001);
        check("s1.sig0", 32'(signature), 32'h1);
        check("s1.notdone", 32'(done), 32'h0);
        cycle("s1.w1", 0, 0, 1, 4'b0000);
        check("s1.sig1", 32'(signature), 32'h2);
        check("s1.done", 32'(done), 32'h1);
        check("s1.pass", 32'(pass), 32'h1);
        cycle("s1.frozen", 0, 0, 1, 4'b1111);
        check("s1.frozen_sig", 32'(signature), 32'h2);

        // Start in DONE reseeds; stream giving 0011 must fail.
        cycle("s2.start", 1, 0, 0, 4'h0);
        check("s2.busy", 32'(busy), 32'h1);
        check("s2.done", 32'(done), 32'h0);
        check("s2.seed", 32'(signature), 32'h0);
        cycle("s2.w0", 0, 0, 1, 4'b0001);
        cycle("s2.w1", 0, 0, 1, 4'b0001);
        check("s2.sig", 32'(signature), 32'h3);
        check("s2.nopass", 32'(pass), 32'h0);

        // Gaps of three idle cycles between words; start mid-session ignored.
        cycle("s3.start", 1, 0, 0, 4'h0);
        cycle("s3.w0", 0, 0, 1, 4'b0001);
        for (int i = 0; i < 3; i++) cycle("s3.gap", (i == 1), 0, 0, 4'hF);
        check("s3.gap_sig", 32'(signature), 32'h1);
        check("s3.gap_busy", 32'(busy), 32'h1);
        cycle("s3.w1", 0, 0, 1, 4'b0000);
        check("s3.sig", 32'(signature), 32'h2);
        check("s3.done", 32'(done), 32'h1);

        // Abort after first word, then fresh session.
        cycle("s4.start", 1, 0, 0, 4'h0);
        cycle("s4.w0", 0, 0, 1, 4'b0111);
        cycle("s4.abort", 1, 1, 1, 4'b0101);
        check("s4.abort_sig", 32'(signature), 32'h0);
        check("s4.abort_busy", 32'(busy), 32'h0);
        cycle("s4.idle_data", 0, 0, 1, 4'b0101);
        check("s4.idle_sig", 32'(signature), 32'h0);
        cycle("s4.start2", 1, 0, 0, 4'h0);
        cycle("s4.w0b", 0, 0, 1, 4'b0001);
        cycle("s4.w1b", 0, 0, 1, 4'b0000);
        check("s4.fresh_sig", 32'(signature), 32'h2);
        check("s4.fresh_pass", 32'(pass), 32'h1);

        // Asynchronous reset mid-COMPACT, away from any clock edge.
        cycle("s5.start", 1, 0, 0, 4'h0);
        cycle("s5.w0", 0, 0, 1, 4'b1001);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("s5.rst_sig",  32'(signature), 32'h0);
        check("s5.rst_busy", 32'(busy), 32'h0);
        check("s5.rst_done", 32'(done), 32'h0);
        #2;
        rst_n = 1'b1;
        cycle("s5.after", 0, 0, 1, 4'b0110);
        check("s5.after_busy", 32'(busy), 32'h0);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 600; i++) begin
            cycle("rnd", ($urandom_range(0, 5) == 0), ($urandom_range(0, 31) == 0),
                  1'($urandom_range(0, 1)), 4'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
